fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
//
// PURPOSE
//  Instruction queue between instruction_fetch and the decode stage. Buffers up to
//  DEPTH {pc, instruction} pairs with valid/ready handshakes on both sides, and
//  predecodes each word for illegal encodings. Decouples fetch from decode stalls;
//  a single-cycle flush discards all in-flight words on branch/jump redirect.
//
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >= 2
//  XLEN   32  program counter width
//
// PORTS
//  clk        in   1               rising-edge clock (single clock domain)
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               fetch presents in_pc/in_instr
//  in_ready   out  1               queue can accept this cycle
//  in_pc      in   XLEN            pc of fetched word
//  in_instr   in   32              fetched instruction word
//  flush      in   1               discard all entries (redirect)
//  out_valid  out  1               head entry valid to decode
//  out_ready  in   1               decode consumes head this cycle
//  out_pc     out  XLEN            pc of head entry
//  out_instr  out  32              head instruction word
//  out_illegal out 1               head word fails predecode
//  count      out  $clog2(DEPTH)+1 current occupancy
//
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0; out_valid=0,
//    in_ready=1, out_pc=0, out_instr=32'h00000013 (NOP), out_illegal=0. Storage
//    array contents need not be cleared. Reset mid-operation drops all entries.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH), combinational from registered count only; never
//    depends on out_ready (no pass-through when full).
//  - out_valid = (count != 0). No empty bypass: word pushed in cycle N is visible
//    at out_* in cycle N+1 earliest (latency 1).
//  - out_pc/out_instr/out_illegal read from entry rd_ptr; when empty they show
//    0 / NOP / 0 (never stale data).
//  - push & pop same cycle: count unchanged, both pointers advance; legal at any
//    count 1..DEPTH-1. At count==DEPTH only pop occurs; at 0 only push.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0; FIFO order
//    preserved across wrap.
//  - flush (synchronous, highest priority): next cycle count=0, pointers=0,
//    out_valid=0; a push or pop in the flush cycle is ignored/discarded.
//  - Predecode computed at push and stored with entry (1 extra bit):
//    illegal = (instr[1:0] != 2'b11) | (instr == 32'h0) | (instr == 32'hFFFFFFFF).
//    No compressed-ISA support; 16-bit encodings are illegal.
//  - Holding in_valid with in_ready=0 is legal; fetch keeps data stable.
//
// STRUCTURE
//  - Shared package riscv_pkg: ILEN=32, NOP_INSTR=32'h00000013, opcode localparams,
//    typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr; logic illegal;}.
//  - One sub-module: instr_predecode (combinational, 32-bit in -> illegal flag),
//    reused later by decode. Queue storage, pointers and count live in this module.
//
// TESTING
//  1. Assert rst with clk running -> out_valid=0, in_ready=1, count=0,
//     out_instr=32'h00000013 immediately (async), held until release.
//  2. Push pc=0x0/0x00500093 then pc=0x4/0x00100113, out_ready=0 -> count=2,
//     out_pc=0x0, out_instr=0x00500093, out_valid first high the cycle after push 1.
//  3. Push 5 words, out_ready=0 -> count=4, in_ready=0, 5th held; one pop ->
//     in_ready=1 next cycle, 5th accepted, order 1..5 at output.
//  4. Continuous push+pop with count=2 for 10 cycles -> count stays 2, pcs emerge
//     0x0,0x4,0x8.. in order across pointer wrap.
//  5. count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0,
//     flushed-cycle word never appears at output.
//  6. Push 0x00000000, 0x00004501, 0x00000013 -> out_illegal=1,1,0 in order.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   ILEN          instruction width
//   XLEN_DEFAULT  default program counter width
//   NOP_INSTR     canonical NOP (addi x0, x0, 0), shown by empty queues
//   OPC_*         base-ISA major opcodes (instr[6:0])
//   fetch_entry_t {pc, instr, illegal} record passed from fetch to decode
package riscv_pkg;

    localparam int ILEN         = 32;
    localparam int XLEN_DEFAULT = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN-1:0]         instr;
        logic                    illegal;
    } fetch_entry_t;

    // 32-bit encodings have both low bits set; anything else is a
    // compressed (16-bit) encoding, which this core does not support.
    function automatic logic is_32bit_encoding(input logic [ILEN-1:0] instr);
        return instr[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/instr_predecode.sv
// Combinational predecode of one instruction word.
//   instr    in   ILEN  instruction word
//   illegal  out  1     word is a compressed encoding, all-zeros or all-ones
module instr_predecode
    import riscv_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic            illegal
);

    // All-zeros and all-ones are reserved as guaranteed-illegal patterns so
    // that fetches from unprogrammed or erased memory trap immediately.
    assign illegal = !is_32bit_encoding(instr)
                   | (instr == '0)
                   | (instr == '1);

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Holds up to DEPTH
// {pc, instr, illegal} entries with valid/ready on both sides; the illegal
// flag is predecoded on the way in and stored alongside the word.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   fetch handshake, in_pc/in_instr payload
//   flush               discard every entry (redirect), wins over push/pop
//   out_valid/out_ready decode handshake, out_pc/out_instr/out_illegal head
//   count               current occupancy
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [ILEN-1:0]        in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [ILEN-1:0]        out_instr,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            illegal;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          in_illegal;
    logic          push;
    logic          pop;

    instr_predecode u_predecode (
        .instr   (in_instr),
        .illegal (in_illegal)
    );

    // Ready comes from registered occupancy only: a full queue never
    // accepts, even when decode is draining in the same cycle.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, illegal: in_illegal};
        end
    end

    assign head = mem[rd_ptr];

    // An empty queue presents a clean NOP rather than whatever stale entry
    // the read pointer happens to address.
    assign out_pc      = out_valid ? head.pc      : '0;
    assign out_instr   = out_valid ? head.instr   : NOP_INSTR;
    assign out_illegal = out_valid ? head.illegal : 1'b0;

    assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .count       (count)
    );

    fetch_entry_t exp_q[$];
    fetch_entry_t pend_item;
    bit           pend_push = 1'b0;
    bit           mon_en = 1'b0;
    int           checks = 0;
    int           failures = 0;
    int           pops_seen = 0;
    logic [31:0]  next_pc = '0;

    function automatic logic ref_illegal(input logic [31:0] w);
        return ((w & 32'h3) != 32'h3) || (w == 32'h0) || (w == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares occupancy/handshake every cycle, and on every pop
    // compares the head against the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pend_push = 1'b0;
            end else if (mon_en) begin
                chk("count", 64'(count), 64'(exp_q.size()));
                chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() == 0) begin
                    chk("empty_pc", 64'(out_pc), 64'h0);
                    chk("empty_instr", 64'(out_instr), 64'h13);
                    chk("empty_illegal", 64'(out_illegal), 64'h0);
                end
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (out_ready && exp_q.size() != 0) begin
                        fetch_entry_t e;
                        e = exp_q.pop_front();
                        chk("head_pc", 64'(out_pc), 64'(e.pc));
                        chk("head_instr", 64'(out_instr), 64'(e.instr));
                        chk("head_illegal", 64'(out_illegal), 64'(e.illegal));
                        pops_seen++;
                    end
                    if (pend_push) exp_q.push_back(pend_item);
                end
                pend_push = 1'b0;
            end
        end
    end

    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                        input bit fl, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        pend_item.pc      = pc;
        pend_item.instr   = ins;
        pend_item.illegal = ref_illegal(ins);
        acc = iv && !fl && (exp_q.size() != DEPTH);
        pend_push = acc;
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(1'b0, 32'h0, 32'h0, 1'b0, ordy, a);
    endtask

    task automatic push_word(input logic [31:0] pc, input logic [31:0] ins, input bit ordy);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            step(1'b1, pc, ins, 1'b0, ordy, a);
            n++;
        end
        checks++;
        if (!a) begin
            failures++;
            $display("FAIL push_timeout actual=not_accepted required=accepted pc=%0h", pc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            idle(1'b1);
            n++;
        end
        idle(1'b0);
        idle(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return {16'h0, 16'($urandom) & 16'hFFFC};
            3:       return $urandom;
            default: return $urandom | 32'h3;
        endcase
    endfunction

    initial begin
        bit          a;
        logic [31:0] cur_pc;
        logic [31:0] cur_ins;
        bit          have;
        int          p5;

        // Reset asserted with the clock running.
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        #15;
        chk("rst_hold_out_instr", 64'(out_instr), 64'h13);
        chk("rst_hold_out_pc", 64'(out_pc), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Two pushes with decode stalled; head stays on the first word.
        step(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, a);
        @(negedge clk);
        chk("t2_valid_before_edge", 64'(out_valid), 64'h0);
        step(1'b1, 32'h4, 32'h0010_0113, 1'b0, 1'b0, a);
        @(negedge clk);
        chk("t2_valid_after_push1", 64'(out_valid), 64'h1);
        idle(1'b0);
        @(negedge clk);
        chk("t2_count", 64'(count), 64'h2);
        chk("t2_head_pc", 64'(out_pc), 64'h0);
        chk("t2_head_instr", 64'(out_instr), 64'h0050_0093);
        drain();

        // Fill past capacity: fifth word held until one pop frees a slot.
        for (int i = 0; i < 4; i++) push_word(32'h100 + 32'(i * 4), 32'h0000_0013 + 32'(i << 7), 1'b0);
        step(1'b1, 32'h110, 32'h0000_0213, 1'b0, 1'b0, a);
        chk("t3_fifth_held", 64'(a), 64'h0);
        step(1'b1, 32'h110, 32'h0000_0213, 1'b0, 1'b1, a);
        chk("t3_fifth_held_during_pop", 64'(a), 64'h0);
        step(1'b1, 32'h110, 32'h0000_0213, 1'b0, 1'b0, a);
        chk("t3_fifth_accepted", 64'(a), 64'h1);
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap.
        next_pc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            push_word(next_pc, 32'h0000_0093 + 32'(i << 20), 1'b0);
            next_pc += 4;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, next_pc, 32'h0000_0093 + 32'((i + 2) << 20), 1'b0, 1'b1, a);
            chk("t4_accept", 64'(a), 64'h1);
            next_pc += 4;
        end
        drain();

        // Flush at count 3 with a push in the same cycle.
        for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i * 4), 32'h0000_0033, 1'b0);
        step(1'b1, 32'h20C, 32'hDEAD_BEE3, 1'b1, 1'b1, a);
        idle(1'b0);
        @(negedge clk);
        chk("t5_count", 64'(count), 64'h0);
        chk("t5_out_valid", 64'(out_valid), 64'h0);
        drain();

        // Predecode of illegal and legal encodings.
        push_word(32'h300, 32'h0000_0000, 1'b0);
        push_word(32'h304, 32'h0000_4501, 1'b0);
        push_word(32'h308, 32'h0000_0013, 1'b0);
        drain();

        // Asynchronous reset in the middle of operation.
        for (int i = 0; i < 3; i++) push_word(32'h400 + 32'(i * 4), 32'h0000_0013, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        chk("arst_out_instr", 64'(out_instr), 64'h13);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0);

        // Randomized traffic: words held stable until accepted.
        have = 1'b0;
        p5 = pops_seen;
        next_pc = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            bit iv, fl, ordy;
            if (!have) begin
                cur_pc  = next_pc;
                cur_ins = rand_instr();
                next_pc += 4;
            end
            iv   = have || ($urandom_range(0, 99) < 65);
            ordy = ($urandom_range(0, 99) < 55);
            fl   = ($urandom_range(0, 99) < 3);
            step(iv, cur_pc, cur_ins, fl, ordy, a);
            have = iv && !a && !fl;
        end
        drain();
        checks++;
        if (pops_seen - p5 < 100) begin
            failures++;
            $display("FAIL random_pops actual=%0d required>=100", pops_seen - p5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
